// File: rtl/param_cpu.sv
// param_cpu: parametrised multi-cycle CPU core.
//
// Fetches IW-bit instructions from a combinational instruction port and
// executes them against a 2**RA-entry register file of DW-bit registers.
// Data accesses use a request/acknowledge handshake so slow memories can
// stall the core.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   imem_addr   out  fetch address (the PC register itself)
//   imem_data   in   instruction at imem_addr, combinationally valid
//   dmem_req    out  data access request, held until dmem_ack
//   dmem_we     out  1 = store, 0 = load
//   dmem_addr   out  R[rs] resized to AW
//   dmem_wdata  out  R[rd] (store data)
//   dmem_rdata  in   load data, sampled on the edge where dmem_ack = 1
//   dmem_ack    in   completes the outstanding request
//   retire      out  one-cycle pulse after an instruction completes
//   halted      out  core stopped by HALT until reset
//   dbg_state   out  current FSM state (FETCH=0, EXEC=1, MEM=2, HALT=3)
//
// Data handshake: dmem_req rises on the edge that enters MEM and holds
// dmem_we/dmem_addr/dmem_wdata stable; the transfer completes on the first
// rising edge where dmem_req and dmem_ack are both 1, and dmem_req is low in
// the following cycle. dmem_ack is ignored whenever no request is pending.
module param_cpu #(
  parameter int DW = 8,
  parameter int RA = 2,
  parameter int AW = 8,
  localparam int IW = 4 + 2 * RA
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic          retire,
  output logic          halted,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_LDI  = 4'd5;
  localparam logic [3:0] OP_ST   = 4'd6;
  localparam logic [3:0] OP_LD   = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_BZ   = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd15;

  state_t          state, state_nxt;
  logic [AW-1:0]   pc;
  logic [IW-1:0]   ir;
  logic            z_flag;
  logic [DW-1:0]   regs [0:(1 << RA) - 1];

  logic [3:0]      op;
  logic [RA-1:0]   rd, rs;
  logic [DW-1:0]   rd_val, rs_val, alu_res, imm;
  logic [AW-1:0]   off, pc_inc, pc_off;

  assign imem_addr = pc;
  assign dbg_state = state;

  // Instruction decode and ALU; operands are read before the completing
  // edge, so an instruction always sees the old value of its destination.
  always_comb begin
    op      = ir[IW-1 -: 4];
    rd      = ir[2*RA-1 -: RA];
    rs      = ir[RA-1:0];
    rd_val  = regs[rd];
    rs_val  = regs[rs];
    imm     = DW'(rs);
    off     = AW'(ir[2*RA-1:0]);
    pc_inc  = pc + AW'(1);
    pc_off  = pc + off;
    case (op)
      OP_ADD:  alu_res = rd_val + rs_val;
      OP_SUB:  alu_res = rd_val - rs_val;
      OP_AND:  alu_res = rd_val & rs_val;
      OP_OR:   alu_res = rd_val | rs_val;
      default: alu_res = '0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (op == OP_ST || op == OP_LD) state_nxt = ST_MEM;
        else if (op == OP_HALT)         state_nxt = ST_HALT;
        else                            state_nxt = ST_FETCH;
      end
      ST_MEM:  if (dmem_ack) state_nxt = ST_FETCH;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_FETCH;
    else        state <= state_nxt;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= '0;
      ir         <= '0;
      z_flag     <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      retire     <= 1'b0;
      halted     <= 1'b0;
      for (int i = 0; i < (1 << RA); i++) regs[i] <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        ST_FETCH: ir <= imem_data;
        ST_EXEC: begin
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              regs[rd] <= alu_res;
              z_flag   <= (alu_res == '0);
              pc       <= pc_inc;
              retire   <= 1'b1;
            end
            OP_LDI: begin
              regs[rd] <= imm;
              pc       <= pc_inc;
              retire   <= 1'b1;
            end
            OP_ST, OP_LD: begin
              dmem_req   <= 1'b1;
              dmem_we    <= (op == OP_ST);
              dmem_addr  <= AW'(rs_val);
              dmem_wdata <= rd_val;
            end
            OP_JMP: begin
              pc     <= pc_off;
              retire <= 1'b1;
            end
            OP_BZ: begin
              pc     <= z_flag ? pc_off : pc_inc;
              retire <= 1'b1;
            end
            OP_HALT: begin
              // PC stays on the HALT instruction.
              halted <= 1'b1;
              retire <= 1'b1;
            end
            default: begin
              pc     <= pc_inc;
              retire <= 1'b1;
            end
          endcase
        end
        ST_MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) regs[rd] <= dmem_rdata;
            pc     <= pc_inc;
            retire <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_cpu.sv
// Testbench for param_cpu: runs short programs from a bench-side instruction
// memory, answers data requests with a configurable ack delay, and compares
// stores and post-retire PCs against expected queues.
module tb_param_cpu;
  localparam int DW = 8;
  localparam int RA = 2;
  localparam int AW = 8;
  localparam int IW = 4 + 2 * RA;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic          dmem_req, dmem_we, dmem_ack;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic          retire, halted;
  logic [1:0]    dbg_state;

  logic [IW-1:0] imem [256];
  logic [DW-1:0] dmem [256];
  assign imem_data = imem[imem_addr];

  param_cpu #(.DW(DW), .RA(RA), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .retire(retire), .halted(halted), .dbg_state(dbg_state)
  );

  // Scoreboard
  logic [15:0]   exp_q[$];     // {addr, wdata} of expected stores, in order
  logic [AW-1:0] exp_pc_q[$];  // expected PC after each retire
  int n_checks = 0;
  int n_err = 0;

  int            ack_delay = 0;
  int            wait_cnt = 0;
  bit            req_seen = 0;
  bit            acked = 0;
  logic [AW-1:0] l_addr;
  logic          l_we;
  logic [DW-1:0] l_wdata;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Driver: advance one clock, then observe outputs and drive the memory side.
  task automatic tick();
    @(posedge clk);
    #1;
    if (retire) begin
      if (exp_pc_q.size() == 0) check("pc_unexpected_retire", 1, 0);
      else check("pc_after_retire", 32'(imem_addr), 32'(exp_pc_q.pop_front()));
    end
    if (dmem_req) begin
      check("no_retire_in_mem", 32'(retire), 0);
      if (!req_seen) begin
        req_seen = 1; acked = 0; wait_cnt = 0;
        l_addr = dmem_addr; l_we = dmem_we; l_wdata = dmem_wdata;
        if (dmem_we) begin
          if (exp_q.size() == 0) check("st_unexpected", 1, 0);
          else check("st_addr_data", 32'({dmem_addr, dmem_wdata}), 32'(exp_q.pop_front()));
        end
      end else begin
        check("req_drop_after_ack", 32'(acked), 0);
        check("hold_addr", 32'(dmem_addr), 32'(l_addr));
        check("hold_we", 32'(dmem_we), 32'(l_we));
        check("hold_wdata", 32'(dmem_wdata), 32'(l_wdata));
      end
      if (wait_cnt >= ack_delay) begin
        dmem_ack = 1'b1; acked = 1;
        dmem_rdata = dmem[dmem_addr];
      end else begin
        dmem_ack = 1'b0;
        dmem_rdata = DW'($urandom_range(0, 255));
        wait_cnt++;
      end
    end else begin
      // Noise on ack/rdata outside a request must be ignored by the core.
      req_seen = 0;
      dmem_ack = 1'($urandom_range(0, 1));
      dmem_rdata = DW'($urandom_range(0, 255));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req"}, 32'(dmem_req), 0);
    check({tag, "_we"}, 32'(dmem_we), 0);
    check({tag, "_addr"}, 32'(dmem_addr), 0);
    check({tag, "_wdata"}, 32'(dmem_wdata), 0);
    check({tag, "_retire"}, 32'(retire), 0);
    check({tag, "_halted"}, 32'(halted), 0);
    check({tag, "_imem_addr"}, 32'(imem_addr), 0);
  endtask

  // Holds reset low for two cycles, checks the reset state, then releases
  // reset 1 time unit after a rising edge.
  task automatic do_reset();
    reset = 1'b0;
    exp_q.delete();
    exp_pc_q.delete();
    req_seen = 0;
    repeat (2) tick();
    check_outputs_zero("rst");
    reset = 1'b1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = '0;
  endtask

  task automatic run_until_halt(input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    check("halt_reached", 32'(halted), 1);
    check("dbg_state_halt", 32'(dbg_state), 3);
    check("st_q_empty", 32'(exp_q.size()), 0);
    check("pc_q_empty", 32'(exp_pc_q.size()), 0);
  endtask

  initial begin
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    for (int i = 0; i < 256; i++) dmem[i] = DW'($urandom_range(0, 255));
    dmem[8'h20] = 8'hA5;

    // Reset, then NOPs: first retire two cycles after release.
    clear_imem();
    do_reset();
    exp_pc_q.push_back(8'd1);
    tick();
    check("first_retire_c1", 32'(retire), 0);
    tick();
    check("first_retire_c2", 32'(retire), 1);

    // LDI/LDI/ADD/SUB then BZ taken (Z=1): PC 4 -> 7; store R1 to [R2=0].
    clear_imem();
    imem[0] = 8'h57; imem[1] = 8'h5A; imem[2] = 8'h16; imem[3] = 8'h2A;
    imem[4] = 8'h93; imem[5] = 8'hF0; imem[7] = 8'h66; imem[8] = 8'hF0;
    ack_delay = $urandom_range(0, 2);
    do_reset();
    exp_pc_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd7, 8'd8, 8'd8};
    exp_q = '{16'h0005};
    run_until_halt(100);

    // Same with R2 != 0 before BZ: not taken, PC 4 -> 5.
    clear_imem();
    imem[0] = 8'h57; imem[1] = 8'h5A; imem[2] = 8'h16; imem[3] = 8'h2B;
    imem[4] = 8'h93; imem[5] = 8'h66; imem[6] = 8'hF0; imem[7] = 8'hF0;
    ack_delay = $urandom_range(0, 2);
    do_reset();
    exp_pc_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd6};
    exp_q = '{16'h0205};
    run_until_halt(100);

    // ST with R1=5, R2=0x20 and a 3-cycle ack delay; LD 0xA5 keeps Z=1.
    clear_imem();
    imem[0] = 8'h57; imem[1] = 8'h5A; imem[2] = 8'h16;
    imem[3] = 8'h1A; imem[4] = 8'h1A; imem[5] = 8'h1A; imem[6] = 8'h1A;
    imem[7] = 8'h66; imem[8] = 8'h2F; imem[9] = 8'h76; imem[10] = 8'h92;
    imem[11] = 8'hF0; imem[12] = 8'h64; imem[13] = 8'hF0;
    ack_delay = 3;
    do_reset();
    exp_pc_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10,
                 8'd12, 8'd13, 8'd13};
    exp_q = '{16'h2005, 16'h00A5};
    run_until_halt(200);

    // Data wrap: 0 - 1 = 0xFF, then 0xFF + 1 = 0x00 with Z=1.
    clear_imem();
    imem[0] = 8'h59; imem[1] = 8'h26; imem[2] = 8'h66; imem[3] = 8'h16;
    imem[4] = 8'h92; imem[5] = 8'hF0; imem[6] = 8'h64; imem[7] = 8'hF0;
    ack_delay = $urandom_range(0, 2);
    do_reset();
    exp_pc_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd7};
    exp_q = '{16'h01FF, 16'h0000};
    run_until_halt(100);

    // PC wrap: JMP +15 at 0xF5 lands on 0x04.
    clear_imem();
    imem[0] = 8'h85; imem[8'hF5] = 8'h8F; imem[4] = 8'hF0;
    do_reset();
    for (int p = 5; p <= 8'hF5; p++) exp_pc_q.push_back(AW'(p));
    exp_pc_q.push_back(8'd4);
    exp_pc_q.push_back(8'd4);
    run_until_halt(1000);

    // Reset asserted while a store waits for ack.
    clear_imem();
    imem[0] = 8'h59; imem[1] = 8'h66;
    ack_delay = 20;
    do_reset();
    exp_pc_q = '{8'd1};
    exp_q = '{16'h0100};
    begin
      int n;
      n = 0;
      while (!dmem_req && n < 20) begin
        tick();
        n++;
      end
      check("mem_req_seen", 32'(dmem_req), 1);
      tick();
      tick();
      check("mem_wait_req_held", 32'(dmem_req), 1);
      reset = 1'b0;
      #1;
      check("mid_mem_rst_req", 32'(dmem_req), 0);
      check("mid_mem_rst_pc", 32'(imem_addr), 0);
      check("mid_mem_rst_retire", 32'(retire), 0);
    end

    // HALT at 0: halted one cycle after execute, PC frozen afterwards.
    clear_imem();
    imem[0] = 8'hF0;
    do_reset();
    exp_pc_q = '{8'd0};
    tick();
    check("halt_c1_halted", 32'(halted), 0);
    tick();
    check("halt_c2_halted", 32'(halted), 1);
    check("halt_c2_retire", 32'(retire), 1);
    for (int k = 0; k < 6; k++) begin
      imem[0] = IW'($urandom_range(0, 255));
      imem[$urandom_range(1, 255)] = IW'($urandom_range(0, 255));
      tick();
      check("halt_pc_frozen", 32'(imem_addr), 0);
      check("halt_stays", 32'(halted), 1);
      check("halt_no_retire", 32'(retire), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
